// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory between the CPU fetch/execute path
// and the external program loader. The CPU wins by default. A wait counter
// forces a loader grant after MAX_WAIT CPU grants taken while the loader was
// waiting. The loader can also lock the port across a burst with LdLock.
// Every access takes three cycles: Idle -> Issue -> Resp -> Idle.
//
// Ports
//   Clock, Reset          : system clock, synchronous active-high reset
//   CpuReq/We/Addr/WData  : CPU request, held until CpuAck
//   CpuAck, CpuRData      : one-cycle completion pulse and read data
//   LdReq/Lock/We/Addr/WData : loader request, held until LdAck
//   LdAck, LdRData        : one-cycle completion pulse and read data
//   MemAddr/WData/We      : memory macro command (registered)
//   MemRData              : memory read data, one cycle after address
//   Owner                 : 00 none, 01 CPU, 10 loader
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CpuReq,
    input  logic              CpuWe,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic              CpuAck,
    output logic [DATA_W-1:0] CpuRData,
    input  logic              LdReq,
    input  logic              LdLock,
    input  logic              LdWe,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [DATA_W-1:0] LdWData,
    output logic              LdAck,
    output logic [DATA_W-1:0] LdRData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWe,
    input  logic [DATA_W-1:0] MemRData,
    output logic [1:0]        Owner
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE_CPU = 2'd1,
        ST_ISSUE_LD  = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_CPU    = 2'b01;
    localparam logic [1:0] OWN_LD     = 2'b10;
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              we_reg;
    logic [1:0]        owner_reg;
    logic              cpu_ack_reg;
    logic              ld_ack_reg;
    logic [3:0]        wait_cnt_reg;
    logic              locked_reg;

    logic grant_cpu;
    logic grant_ld;

    // Idle arbitration. While locked the CPU is shut out even if the loader
    // is momentarily not requesting; the lock only drops via LdLock=0.
    always_comb begin
        grant_cpu = 1'b0;
        grant_ld  = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (locked_reg) begin
                grant_ld = LdReq;
            end else if (LdReq && (wait_cnt_reg == WAIT_LIMIT)) begin
                grant_ld = 1'b1;
            end else if (CpuReq) begin
                grant_cpu = 1'b1;
            end else if (LdReq) begin
                grant_ld = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            owner_reg    <= OWN_NONE;
            cpu_ack_reg  <= 1'b0;
            ld_ack_reg   <= 1'b0;
            wait_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else begin
            cpu_ack_reg <= 1'b0;
            ld_ack_reg  <= 1'b0;

            // Counts CPU grants taken while the loader is waiting; any cycle
            // without a loader request, or a loader grant, starts over.
            if (!LdReq || grant_ld) begin
                wait_cnt_reg <= '0;
            end else if (grant_cpu && (wait_cnt_reg < WAIT_LIMIT)) begin
                wait_cnt_reg <= wait_cnt_reg + 4'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!LdLock) begin
                        locked_reg <= 1'b0;
                    end
                    if (grant_cpu) begin
                        state_reg <= ST_ISSUE_CPU;
                        addr_reg  <= CpuAddr;
                        wdata_reg <= CpuWData;
                        we_reg    <= CpuWe;
                        owner_reg <= OWN_CPU;
                    end else if (grant_ld) begin
                        state_reg <= ST_ISSUE_LD;
                        addr_reg  <= LdAddr;
                        wdata_reg <= LdWData;
                        we_reg    <= LdWe;
                        owner_reg <= OWN_LD;
                    end
                end
                ST_ISSUE_CPU: begin
                    state_reg   <= ST_RESP;
                    we_reg      <= 1'b0;
                    cpu_ack_reg <= 1'b1;
                end
                ST_ISSUE_LD: begin
                    state_reg  <= ST_RESP;
                    we_reg     <= 1'b0;
                    ld_ack_reg <= 1'b1;
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                    owner_reg <= OWN_NONE;
                    if ((owner_reg == OWN_LD) && LdLock) begin
                        locked_reg <= 1'b1;
                    end else if (!LdLock) begin
                        locked_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // MemWe and the acks are masked by Reset so an access caught by reset
    // neither writes nor completes.
    assign MemAddr  = addr_reg;
    assign MemWData = wdata_reg;
    assign MemWe    = we_reg & ~Reset;
    assign CpuAck   = cpu_ack_reg & ~Reset;
    assign LdAck    = ld_ack_reg & ~Reset;
    assign CpuRData = MemRData;
    assign LdRData  = MemRData;
    assign Owner    = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Randomized bench: a CPU and a loader requester issue reads/writes with random
// addresses, LdLock toggles and occasional resets. A transaction-level model
// (free / in flight / responding, a starvation tally, a lock flag and a shadow
// memory) predicts each cycle's Owner, acks, memory command and read data.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 4;
    localparam int N_CYCLES = 4000;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              CpuReq = 1'b0;
    logic              CpuWe = 1'b0;
    logic [ADDR_W-1:0] CpuAddr = '0;
    logic [DATA_W-1:0] CpuWData = '0;
    logic              CpuAck;
    logic [DATA_W-1:0] CpuRData;
    logic              LdReq = 1'b0;
    logic              LdLock = 1'b0;
    logic              LdWe = 1'b0;
    logic [ADDR_W-1:0] LdAddr = '0;
    logic [DATA_W-1:0] LdWData = '0;
    logic              LdAck;
    logic [DATA_W-1:0] LdRData;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemWe;
    logic [DATA_W-1:0] MemRData;
    logic [1:0]        Owner;

    logic preload = 1'b1;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_phase;   // 0 free, 1 command at memory, 2 response
    int          m_who;     // 1 CPU, 2 loader
    int          m_starve;  // CPU grants taken while the loader waited
    bit          m_locked;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    bit          m_we;
    logic [15:0] shadow [256];

    bit cpu_pending;
    bit ld_pending;
    int cpu_pct, ld_pct, relock_pct, rst_div;
    int forced_ld_grants = 0;

    always #5 Clock = ~Clock;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .CpuReq  (CpuReq),
        .CpuWe   (CpuWe),
        .CpuAddr (CpuAddr),
        .CpuWData(CpuWData),
        .CpuAck  (CpuAck),
        .CpuRData(CpuRData),
        .LdReq   (LdReq),
        .LdLock  (LdLock),
        .LdWe    (LdWe),
        .LdAddr  (LdAddr),
        .LdWData (LdWData),
        .LdAck   (LdAck),
        .LdRData (LdRData),
        .MemAddr (MemAddr),
        .MemWData(MemWData),
        .MemWe   (MemWe),
        .MemRData(MemRData),
        .Owner   (Owner)
    );

    function automatic logic [15:0] init_word(input int a);
        if (a == 'h12) return 16'hBEEF;
        return 16'((a * 257) ^ 'h5A5A);
    endfunction

    // Memory macro: synchronous single port, read data one cycle after address
    logic [15:0] mem_array [256];
    always @(posedge Clock) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_array[i] <= init_word(i);
        end else if (MemWe) begin
            mem_array[MemAddr] <= MemWData;
        end
        MemRData <= mem_array[MemAddr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_who    = 0;
        m_starve = 0;
        m_locked = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_we     = 1'b0;
    endtask

    task automatic new_cpu_req();
        CpuReq      = 1'b1;
        CpuWe       = 1'($urandom_range(0, 1));
        CpuAddr     = 8'($urandom_range(0, 15));
        CpuWData    = 16'($urandom);
        cpu_pending = 1'b1;
    endtask

    task automatic new_ld_req();
        LdReq      = 1'b1;
        LdWe       = 1'($urandom_range(0, 1));
        LdAddr     = 8'($urandom_range(0, 15));
        LdWData    = 16'($urandom);
        ld_pending = 1'b1;
    endtask

    // Requesters react to the ack of the cycle that just ended.
    task automatic drive_requesters(input int acked);
        if ((rst_div > 0) && ($urandom_range(0, rst_div - 1) == 0)) begin
            Reset       = 1'b1;
            CpuReq      = 1'b0;
            LdReq       = 1'b0;
            cpu_pending = 1'b0;
            ld_pending  = 1'b0;
        end else begin
            Reset = 1'b0;
            if (acked == 1) begin
                cpu_pending = 1'b0;
                CpuReq      = 1'b0;
            end
            if (acked == 2) begin
                ld_pending = 1'b0;
                LdReq      = 1'b0;
            end
            if (!cpu_pending && ($urandom_range(0, 99) < cpu_pct)) new_cpu_req();
            if (!ld_pending && ($urandom_range(0, 99) < ld_pct)) new_ld_req();
            if ($urandom_range(0, 99) < relock_pct) LdLock = ~LdLock;
        end
    endtask

    task automatic run_cycle();
        int exp_owner;
        bit exp_cpu_ack;
        bit exp_ld_ack;
        bit exp_we;
        int win;
        int acked;

        @(negedge Clock);
        exp_owner   = (m_phase == 0) ? 0 : m_who;
        exp_cpu_ack = (m_phase == 2) && (m_who == 1) && !Reset;
        exp_ld_ack  = (m_phase == 2) && (m_who == 2) && !Reset;
        exp_we      = (m_phase == 1) && m_we && !Reset;

        check_val("owner", 32'(Owner), 32'(exp_owner));
        check_val("cpu_ack", 32'(CpuAck), 32'(exp_cpu_ack));
        check_val("ld_ack", 32'(LdAck), 32'(exp_ld_ack));
        check_val("mem_we", 32'(MemWe), 32'(exp_we));
        check_val("mem_addr", 32'(MemAddr), 32'(m_addr));
        check_val("mem_wdata", 32'(MemWData), 32'(m_wdata));
        if (exp_cpu_ack && !m_we) check_val("cpu_rdata", 32'(CpuRData), 32'(shadow[m_addr]));
        if (exp_ld_ack && !m_we) check_val("ld_rdata", 32'(LdRData), 32'(shadow[m_addr]));

        acked = 0;
        if (Reset) begin
            model_reset();
        end else begin
            win = 0;
            if (m_phase == 0) begin
                if (m_locked) begin
                    win = LdReq ? 2 : 0;
                end else if (LdReq && (m_starve == MAX_WAIT)) begin
                    win = 2;
                    forced_ld_grants++;
                end else if (CpuReq) begin
                    win = 1;
                end else if (LdReq) begin
                    win = 2;
                end
            end

            if (!LdReq || (win == 2)) m_starve = 0;
            else if ((win == 1) && (m_starve < MAX_WAIT)) m_starve++;

            if ((m_phase == 2) && (m_who == 2) && LdLock) m_locked = 1'b1;
            else if ((m_phase != 1) && !LdLock) m_locked = 1'b0;

            case (m_phase)
                0: begin
                    if (win != 0) begin
                        m_phase = 1;
                        m_who   = win;
                        m_addr  = (win == 1) ? CpuAddr : LdAddr;
                        m_wdata = (win == 1) ? CpuWData : LdWData;
                        m_we    = (win == 1) ? CpuWe : LdWe;
                    end
                end
                1: begin
                    if (m_we) shadow[m_addr] = m_wdata;
                    m_phase = 2;
                end
                default: begin
                    acked   = m_who;
                    m_phase = 0;
                end
            endcase
        end

        @(posedge Clock);
        #1;
        drive_requesters(acked);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        preload = 1'b0;
        Reset   = 1'b0;
        // First access: CPU read of the preloaded word at 0x12
        CpuReq      = 1'b1;
        CpuWe       = 1'b0;
        CpuAddr     = 8'h12;
        cpu_pending = 1'b1;

        for (int c = 0; c < N_CYCLES; c++) begin
            if (c < 1500) begin
                cpu_pct = 70; ld_pct = 50; relock_pct = 10; rst_div = 97;
            end else if (c < 2000) begin
                cpu_pct = 15; ld_pct = 15; relock_pct = 5; rst_div = 0;
            end else if (c < 2100) begin
                cpu_pct = 0; ld_pct = 0; relock_pct = 0; rst_div = 0;
            end else if (c < 3000) begin
                cpu_pct = 90; ld_pct = 90; relock_pct = 20; rst_div = 40;
            end else begin
                cpu_pct = 50; ld_pct = 50; relock_pct = 3; rst_div = 150;
            end
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous program/data memory between the CPU and the external program loader.
- The CPU is the fetch/execute path sequenced by the control unit. The loader writes or reads back program images.
- CPU has default priority. The loader is protected from starvation by a wait counter and can lock the port for burst programming.
- Sits between the control/datapath and the memory macro. The control unit holds PcWait until CpuAck.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory data width
MAX_WAIT, 4, CPU grants tolerated while LdReq is pending before the loader is forced to win (1..15)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
CpuReq  in  1  CPU access request, held until CpuAck
CpuWe  in  1  CPU write enable, valid with CpuReq
CpuAddr  in  ADDR_W  CPU address
CpuWData  in  DATA_W  CPU write data
CpuAck  out  1  one-cycle completion pulse to CPU
CpuRData  out  DATA_W  read data, valid when CpuAck=1
LdReq  in  1  loader request, held until LdAck
LdLock  in  1  loader requests port retention after the current access
LdWe  in  1  loader write enable
LdAddr  in  ADDR_W  loader address
LdWData  in  DATA_W  loader write data
LdAck  out  1  one-cycle completion pulse to loader
LdRData  out  DATA_W  read data, valid when LdAck=1
MemAddr  out  ADDR_W  memory address
MemWData  out  DATA_W  memory write data
MemWe  out  1  memory write strobe
MemRData  in  DATA_W  memory read data, one cycle after address
Owner  out  2  00 none, 01 CPU, 10 loader (state of current access)

Behaviour:
- Reset values (cycle after Reset high):
  - state=Idle, CpuAck=LdAck=0, MemWe=0, MemAddr=0, MemWData=0, Owner=00, WaitCnt=0, Locked=0.
  - MemWe is also gated by Reset combinationally, so no write occurs in any Reset cycle.
- FSM states: Idle, IssueCpu, IssueLd, Resp. Every access takes exactly 3 cycles: Idle -> Issue -> Resp -> Idle.
- Idle arbitration (evaluated every Idle cycle), in priority order:
  1. Locked=1: only LdReq is considered. CPU waits even if LdReq=0.
  2. LdReq=1 and WaitCnt==MAX_WAIT: grant loader.
  3. CpuReq=1: grant CPU.
  4. LdReq=1: grant loader.
  5. Otherwise stay in Idle.
- Grant registers the winner's Addr/WData/We into internal registers. Requester inputs are ignored afterwards.
- Issue cycle:
  - MemAddr and MemWData are driven from the registered copies.
  - MemWe = registered We.
  - Owner = 01 or 10.
- Resp cycle:
  - Owner's Ack=1 for exactly one cycle.
  - CpuRData and LdRData both equal MemRData (read data of the Issue address). On writes the RData value is don't-care.
  - MemWe=0. MemAddr holds its value.
- Requester handshake: Req must deassert in the cycle after Ack. The next Idle cycle samples the new Req value.
- WaitCnt (4 bits):
  - +1 on each CPU grant while LdReq=1.
  - Clears to 0 on a loader grant, or on any cycle with LdReq=0.
  - Saturates at MAX_WAIT.
- Locked:
  - Set in Resp of a loader access when LdLock=1.
  - Cleared in any Idle or Resp cycle with LdLock=0.
  - Never set by the CPU.
- Simultaneous CpuReq and LdReq with WaitCnt<MAX_WAIT and Locked=0: CPU wins.
- Reset asserted mid-access (Issue or Resp): access abandoned, no Ack issued, return to Idle; requester re-requests after reset.
- Owner is registered and is 00 in Idle.

Test Plan:
- CPU read: preload mem[0x12]=0xBEEF; CpuReq=1, CpuWe=0, CpuAddr=0x12 at cycle 0 -> MemAddr=0x12 at cycle 1; CpuAck=1 and CpuRData=0xBEEF at cycle 2; Owner 00/01/01 over cycles 0/1/2.
- Loader write then CPU read: LdWe=1, LdAddr=0x05, LdWData=0x1234 -> MemWe=1 for exactly one cycle, LdAck the next cycle; subsequent CPU read of 0x05 returns 0x1234.
- Contention and starvation: CpuReq held continuously (re-requesting after every ack) and LdReq=1 with MAX_WAIT=4 -> exactly 4 CPU grants, then a loader grant; WaitCnt back to 0.
- Lock burst: loader performs 3 writes with LdLock=1 while CpuReq=1 -> zero CpuAck during the burst; first CpuAck occurs after the Idle cycle in which LdLock=0.
- Reset in IssueLd cycle of a write to 0x07 (mem[0x07]=0x0000) -> MemWe=0 in that cycle, mem[0x07] stays 0x0000, no LdAck, state Idle, all outputs at reset values.
- Idle: no requests for 10 cycles -> Owner=00, MemWe=0, no Ack pulses.
